// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port memory: one registered issue stage,
// read data returned to the requester two cycles after grant; a losing requester waits at most one cycle.
module mem_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 p0_req,
  input  logic                 p0_we,
  input  logic [ADDR_SIZE-1:0] p0_addr,
  input  logic [WORD_SIZE-1:0] p0_wdata,
  input  logic                 p1_req,
  input  logic                 p1_we,
  input  logic [ADDR_SIZE-1:0] p1_addr,
  input  logic [WORD_SIZE-1:0] p1_wdata,
  output logic                 p0_gnt,
  output logic                 p1_gnt,
  output logic                 p0_rvalid,
  output logic                 p1_rvalid,
  output logic [WORD_SIZE-1:0] p0_rdata,
  output logic [WORD_SIZE-1:0] p1_rdata,
  output logic                 mem_r_en,
  output logic                 mem_w_en,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_w_data,
  input  logic [WORD_SIZE-1:0] mem_r_data
);

  logic                 prio_q, prio_d;
  logic                 iss_vld_q, iss_vld_d;
  logic                 iss_port_q, iss_port_d;
  logic                 iss_we_q, iss_we_d;
  logic [ADDR_SIZE-1:0] iss_addr_q, iss_addr_d;
  logic [WORD_SIZE-1:0] iss_wdata_q, iss_wdata_d;
  logic                 rsp_vld_q, rsp_vld_d;
  logic                 rsp_port_q, rsp_port_d;
  logic                 gnt0, gnt1;

  // A lone requester always wins; on contention the priority pointer decides.
  assign gnt0 = reset & p0_req & (~p1_req | ~prio_q);
  assign gnt1 = reset & p1_req & (~p0_req | prio_q);

  always_comb begin
    prio_d      = prio_q;
    iss_vld_d   = gnt0 | gnt1;
    iss_port_d  = iss_port_q;
    iss_we_d    = iss_we_q;
    iss_addr_d  = iss_addr_q;
    iss_wdata_d = iss_wdata_q;
    if (gnt0) begin
      iss_port_d  = 1'b0;
      iss_we_d    = p0_we;
      iss_addr_d  = p0_addr;
      iss_wdata_d = p0_wdata;
      prio_d      = 1'b1;
    end else if (gnt1) begin
      iss_port_d  = 1'b1;
      iss_we_d    = p1_we;
      iss_addr_d  = p1_addr;
      iss_wdata_d = p1_wdata;
      prio_d      = 1'b0;
    end
    rsp_vld_d  = iss_vld_q & ~iss_we_q;
    rsp_port_d = iss_port_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prio_q      <= 1'b0;
      iss_vld_q   <= 1'b0;
      iss_port_q  <= 1'b0;
      iss_we_q    <= 1'b0;
      iss_addr_q  <= '0;
      iss_wdata_q <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_port_q  <= 1'b0;
    end else begin
      prio_q      <= prio_d;
      iss_vld_q   <= iss_vld_d;
      iss_port_q  <= iss_port_d;
      iss_we_q    <= iss_we_d;
      iss_addr_q  <= iss_addr_d;
      iss_wdata_q <= iss_wdata_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_port_q  <= rsp_port_d;
    end
  end

  // A read caught by reset is suppressed at once; a write already on the bus is allowed to commit.
  assign mem_r_en   = iss_vld_q & ~iss_we_q & reset;
  assign mem_w_en   = iss_vld_q & iss_we_q;
  assign mem_addr   = iss_addr_q;
  assign mem_w_data = iss_wdata_q;

  assign p0_gnt    = gnt0;
  assign p1_gnt    = gnt1;
  assign p0_rvalid = rsp_vld_q & ~rsp_port_q;
  assign p1_rvalid = rsp_vld_q & rsp_port_q;
  assign p0_rdata  = mem_r_data;
  assign p1_rdata  = mem_r_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, then random traffic against a transaction-level model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [15:0] p0_rdata, p1_rdata;
  logic        mem_r_en, mem_w_en;
  logic [15:0] mem_addr, mem_w_data, mem_r_data;

  always #5 clk = ~clk;

  mem_arbiter #(.WORD_SIZE(16), .ADDR_SIZE(16)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
    .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .mem_addr(mem_addr), .mem_w_data(mem_w_data), .mem_r_data(mem_r_data)
  );

  // Memory behind the arbiter: synchronous write, one-cycle read latency.
  logic [15:0] tmem [0:255];
  logic        load;
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) tmem[i] <= (i == 5) ? 16'hBEEF : 16'(16'hA000 + i);
    end else begin
      if (mem_w_en) tmem[mem_addr[7:0]] <= mem_w_data;
      if (mem_r_en) mem_r_data <= tmem[mem_addr[7:0]];
    end
  end

  typedef struct {
    bit rst;
    bit r0; bit we0; logic [15:0] a0; logic [15:0] wd0;
    bit r1; bit we1; logic [15:0] a1; logic [15:0] wd1;
    bit eg0; bit eg1; bit eren; bit ewen; logic [15:0] eaddr;
    bit erv0; bit erv1; logic [15:0] erd;
  } vec_t;

  typedef struct {
    int cyc; bit port; bit we; logic [15:0] addr; logic [15:0] wd; logic [15:0] data;
  } op_t;

  int n_tests = 0, n_fail = 0, cyc = 0;
  op_t ops[$];
  op_t resps[$];
  logic [15:0] shadow [0:255];
  bit m_prio;
  logic [15:0] m_addr, m_wd;
  bit g0_s, g1_s;
  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit r0, bit we0, logic [15:0] a0, logic [15:0] wd0,
                              bit r1, bit we1, logic [15:0] a1, logic [15:0] wd1,
                              bit eg0, bit eg1, bit eren, bit ewen, logic [15:0] eaddr,
                              bit erv0, bit erv1, logic [15:0] erd);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.we0 = we0; v.a0 = a0; v.wd0 = wd0;
    v.r1 = r1; v.we1 = we1; v.a1 = a1; v.wd1 = wd1;
    v.eg0 = eg0; v.eg1 = eg1; v.eren = eren; v.ewen = ewen; v.eaddr = eaddr;
    v.erv0 = erv0; v.erv1 = erv1; v.erd = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic run_cycle(input vec_t v, input bit use_tbl);
    op_t op, o, n;
    bit have_op, rv0e, rv1e, winner, eg0, eg1;
    logic [15:0] rde;
    reset = v.rst;
    p0_req = v.r0; p0_we = v.we0; p0_addr = v.a0; p0_wdata = v.wd0;
    p1_req = v.r1; p1_we = v.we1; p1_addr = v.a1; p1_wdata = v.wd1;
    @(negedge clk);
    have_op = (ops.size() > 0) && (ops[0].cyc == cyc);
    if (have_op) op = ops.pop_front();
    chk("mem_r_en", mem_r_en, have_op && !op.we && v.rst);
    chk("mem_w_en", mem_w_en, have_op && op.we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_w_data", mem_w_data, m_wd);
    rv0e = 0; rv1e = 0; rde = '0;
    if (resps.size() > 0 && resps[0].cyc == cyc) begin
      o = resps.pop_front();
      rv0e = !o.port; rv1e = o.port; rde = o.data;
    end
    chk("p0_rvalid", p0_rvalid, rv0e);
    chk("p1_rvalid", p1_rvalid, rv1e);
    if (rv0e) chk("p0_rdata", p0_rdata, rde);
    if (rv1e) chk("p1_rdata", p1_rdata, rde);
    winner = (v.r0 && v.r1) ? m_prio : v.r1;
    eg0 = v.rst && (v.r0 || v.r1) && !winner;
    eg1 = v.rst && (v.r0 || v.r1) && winner;
    chk("p0_gnt", p0_gnt, eg0);
    chk("p1_gnt", p1_gnt, eg1);
    g0_s = p0_gnt; g1_s = p1_gnt;
    if (use_tbl) begin
      chk("tbl_p0_gnt", p0_gnt, v.eg0);
      chk("tbl_p1_gnt", p1_gnt, v.eg1);
      chk("tbl_mem_r_en", mem_r_en, v.eren);
      chk("tbl_mem_w_en", mem_w_en, v.ewen);
      if (v.eren || v.ewen) chk("tbl_mem_addr", mem_addr, v.eaddr);
      chk("tbl_p0_rvalid", p0_rvalid, v.erv0);
      chk("tbl_p1_rvalid", p1_rvalid, v.erv1);
      if (v.erv0) chk("tbl_p0_rdata", p0_rdata, v.erd);
      if (v.erv1) chk("tbl_p1_rdata", p1_rdata, v.erd);
    end
    if (!v.rst) begin
      ops.delete(); resps.delete();
      m_prio = 0; m_addr = '0; m_wd = '0;
    end else if (eg0 || eg1) begin
      n.port = eg1;
      n.we   = eg1 ? v.we1 : v.we0;
      n.addr = eg1 ? v.a1 : v.a0;
      n.wd   = eg1 ? v.wd1 : v.wd0;
      n.data = shadow[n.addr[7:0]];
      if (n.we) shadow[n.addr[7:0]] = n.wd;
      n.cyc = cyc + 1;
      ops.push_back(n);
      if (!n.we) begin
        n.cyc = cyc + 2;
        resps.push_back(n);
      end
      m_prio = !n.port; m_addr = n.addr; m_wd = n.wd;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    bit pend0, pend1;
    for (int i = 0; i < 256; i++) shadow[i] = (i == 5) ? 16'hBEEF : 16'(16'hA000 + i);
    reset = 0; load = 1;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    @(posedge clk); #1;
    load = 0;
    @(posedge clk); #1;
    m_prio = 0; m_addr = '0; m_wd = '0;

    // reset, single read of preloaded BEEF
    tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,0));
    tbl.push_back(mk(1, 1,0,5,0, 0,0,0,0, 1,0,0,0,0, 0,0,0));
    tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0,1,0,5, 0,0,0));
    tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 1,0,16'hBEEF));
    tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,0));
    // contention straight out of reset
    tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,0));
    tbl.push_back(mk(1, 1,0,0,0, 1,0,1,0, 1,0,0,0,0, 0,0,0));
    tbl.push_back(mk(1, 1,0,0,0, 1,0,1,0, 0,1,1,0,0, 0,0,0));
    tbl.push_back(mk(1, 1,0,0,0, 1,0,1,0, 1,0,1,0,1, 1,0,16'hA000));
    tbl.push_back(mk(1, 1,0,0,0, 1,0,1,0, 0,1,1,0,0, 0,1,16'hA001));
    tbl.push_back(mk(1, 1,0,0,0, 1,0,1,0, 1,0,1,0,1, 1,0,16'hA000));
    tbl.push_back(mk(1, 1,0,0,0, 1,0,1,0, 0,1,1,0,0, 0,1,16'hA001));
    tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0,1,0,1, 1,0,16'hA000));
    tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,1,16'hA001));
    // write then read of the same address on the next cycle
    tbl.push_back(mk(1, 0,0,0,0, 1,1,9,16'h1234, 0,1,0,0,0, 0,0,0));
    tbl.push_back(mk(1, 1,0,9,0, 0,0,0,0, 1,0,0,1,9, 0,0,0));
    tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0,1,0,9, 0,0,0));
    tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 1,0,16'h1234));
    // pointer holds across idle cycles
    tbl.push_back(mk(1, 0,0,0,0, 1,0,2,0, 0,1,0,0,0, 0,0,0));
    tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0,1,0,2, 0,0,0));
    tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,1,16'hA002));
    tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,0));
    tbl.push_back(mk(1, 1,0,3,0, 1,0,4,0, 1,0,0,0,0, 0,0,0));
    tbl.push_back(mk(1, 0,0,0,0, 1,0,4,0, 0,1,1,0,3, 0,0,0));
    tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0,1,0,4, 1,0,16'hA003));
    tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,1,16'hA004));
    // reset hits an in-flight read
    tbl.push_back(mk(1, 1,0,6,0, 0,0,0,0, 1,0,0,0,0, 0,0,0));
    tbl.push_back(mk(0, 1,0,7,0, 1,0,8,0, 0,0,0,0,0, 0,0,0));
    tbl.push_back(mk(0, 1,0,7,0, 1,0,8,0, 0,0,0,0,0, 0,0,0));
    tbl.push_back(mk(1, 1,0,7,0, 1,0,8,0, 1,0,0,0,0, 0,0,0));
    tbl.push_back(mk(1, 0,0,0,0, 1,0,8,0, 0,1,1,0,7, 0,0,0));
    tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0,1,0,8, 1,0,16'hA007));
    tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,1,16'hA008));
    // reset hits an in-flight write, which still commits
    tbl.push_back(mk(1, 0,0,0,0, 1,1,10,16'h5555, 0,1,0,0,0, 0,0,0));
    tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,1,10, 0,0,0));
    tbl.push_back(mk(1, 1,0,10,0, 0,0,0,0, 1,0,0,0,0, 0,0,0));
    tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0,1,0,10, 0,0,0));
    tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 1,0,16'h5555));

    foreach (tbl[i]) run_cycle(tbl[i], 1'b1);

    v = mk(1, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,0);
    pend0 = 0; pend1 = 0;
    for (int k = 0; k < 3000; k++) begin
      if (!pend0 && $urandom_range(0, 9) < 6) begin
        pend0 = 1; v.we0 = 1'($urandom_range(0, 1));
        v.a0 = 16'($urandom_range(0, 15)); v.wd0 = 16'($urandom);
      end
      if (!pend1 && $urandom_range(0, 9) < 6) begin
        pend1 = 1; v.we1 = 1'($urandom_range(0, 1));
        v.a1 = 16'($urandom_range(0, 15)); v.wd1 = 16'($urandom);
      end
      v.r0 = pend0; v.r1 = pend1;
      v.rst = ($urandom_range(0, 49) != 0);
      run_cycle(v, 1'b0);
      if (g0_s) pend0 = 0;
      if (g1_s) pend1 = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter sharing the single-port `mem` (16-bit words, 16-bit addresses) between the CPU instruction-fetch port (port 0) and the CPU load/store port (port 1). Sits between `cpu` and `mem`, registers the winning request into one issue stage, and routes read data back to the requester. It sustains one memory access per cycle, preserves request order, and bounds the wait of any requester to one lost arbitration.

## Interface
- `WORD_SIZE`, 16, data width
- `ADDR_SIZE`, 16, address width

- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-low reset (sampled on `clk` rising edge; 0 = reset)
- `p0_req` / `p1_req`  in  1  request; held high with stable fields until granted
- `p0_we` / `p1_we`  in  1  1 = write, 0 = read
- `p0_addr` / `p1_addr`  in  ADDR_SIZE  access address
- `p0_wdata` / `p1_wdata`  in  WORD_SIZE  write data
- `p0_gnt` / `p1_gnt`  out  1  combinational; high in the cycle the request is accepted
- `p0_rvalid` / `p1_rvalid`  out  1  registered; one-cycle pulse, read data valid
- `p0_rdata` / `p1_rdata`  out  WORD_SIZE  equal to `mem_r_data`; meaningful only while the matching `rvalid` is high
- `mem_r_en`  out  1  registered memory read enable
- `mem_w_en`  out  1  registered memory write enable
- `mem_addr`  out  ADDR_SIZE  registered memory address
- `mem_w_data`  out  WORD_SIZE  registered memory write data
- `mem_r_data`  in  WORD_SIZE  memory read data, valid the cycle after `mem_r_en`

## Operation
- State: priority pointer `prio` (0/1), issue register (valid, port id, we, addr, wdata), response register (valid, port id).
- Arbitration, evaluated every cycle while `reset` = 1:
  - Only one port requesting: that port wins.
  - Both requesting: port `prio` wins.
  - Neither requesting: no grant; `prio` unchanged.
- On a grant to port i:
  - `pi_gnt` = 1 in that cycle.
  - The request is captured into the issue register at the edge.
  - `prio` becomes the other port.
- Issue register drives the memory outputs directly:
  - `mem_r_en` = valid & !we, `mem_w_en` = valid & we.
  - `mem_addr` and `mem_w_data` come from the issue register and hold their last value when idle.
- A read in the issue stage loads the response register (valid, port id) at the next edge. The response register drives `pi_rvalid` for that port only. `pi_rdata` = `mem_r_data` for both ports at all times.
- Writes produce no response.
- At most one grant per cycle, and never `p0_gnt` & `p1_gnt`.
- Ordering: accesses reach memory in grant order. A write granted in cycle T followed by a read of the same address granted in T+1 returns the new data.
- Reset (`reset` = 0 at an edge):
  - `prio` ← 0.
  - Issue valid ← 0, response valid ← 0.
  - `mem_r_en`, `mem_w_en`, `mem_addr`, `mem_w_data`, `p0_rvalid`, `p1_rvalid` all 0 after the edge.
  - While `reset` = 0, both `gnt` outputs are forced 0.
- Reset mid-operation: in-flight reads are dropped with no `rvalid`. An in-flight write whose `mem_w_en` is high in the reset cycle still commits; nothing later is issued.

## Timing
- Read latency:
  - Grant in cycle T.
  - `mem_r_en` high in T+1.
  - `pi_rvalid` high with data in T+2.
- Write: grant in T; `mem_w_en` high in T+1; memory updated at the end of T+1.
- Throughput: one access per cycle. Back-to-back grants to alternating ports are allowed every cycle.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1,... A waiting port is granted no later than the cycle after it first loses.
- A requester drops `req` in the cycle after seeing `gnt`, or keeps it high to present a new request. A still-high `req` after a grant is a new request.
- First cycle after reset release: both ports requesting → port 0 wins.

## Test plan
- Reset then single read:
  - Preload mem[5]=16'hBEEF, release reset, `p0_req` read addr 5 in cycle 1.
  - Required: `p0_gnt` in cycle 1, `mem_r_en` in cycle 2 with `mem_addr`=5, `p0_rvalid` and `p0_rdata`=16'hBEEF in cycle 3, `p1_rvalid` 0 throughout.
- Contention:
  - Both ports hold read requests (p0 addr 0, p1 addr 1) for 6 cycles from reset release.
  - Required: grants 0,1,0,1,0,1, no cycle with both grants, `rvalid` pulses alternate two cycles behind.
- Write-then-read hazard:
  - p1 writes 16'h1234 to addr 9 in cycle T; p0 reads addr 9 in cycle T+1.
  - Required: p0 receives 16'h1234 in T+3.
- Idle pointer hold:
  - p1 granted alone, then 3 idle cycles, then both request.
  - Required: port 0 granted first.
- Reset mid-read:
  - p0 read granted in T; `reset`=0 in T+1.
  - Required: no `p0_rvalid` ever for that read; `mem_r_en`=0 and `gnt` outputs 0 while `reset`=0; normal operation resumes after release.
